// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding and the round-robin pick function.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARMED  = 3'd2,
    DRAIN  = 3'd3,
    GAP    = 3'd4
  } arb_state_t;

  // First set bit at or above ptr, wrapping modulo n (n <= 8).
  function automatic logic [2:0] rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    int k;
    rr_pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k[2:0]]) rr_pick = k[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin priority encoder.
// Returns the first pending requester at or after the pointer.
module rr_select
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [7:0] w_req;
  logic [2:0] w_ptr;
  logic [2:0] w_pick;

  assign w_req   = 8'(i_req);
  assign w_ptr   = 3'(i_ptr);
  assign w_pick  = rr_pick(w_req, w_ptr, N);
  assign o_valid = |i_req;
  assign o_idx   = IW'(w_pick);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between requesters.
// Launches a byte, follows TxD_busy through the frame, then an idle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           active,
  output logic                           tx_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] ARM_LAST = 8'(ARM_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST =
    8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t r_state;
  arb_state_t w_next;

  logic [7:0]             r_cnt;
  logic [IW-1:0]          r_ptr;
  logic [IW-1:0]          r_owner;
  logic [NUM_REQ-1:0]     r_ack;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_tx_err;

  logic                   w_valid;
  logic [IW-1:0]          w_idx;
  logic [IW-1:0]          w_next_ptr;
  logic [NUM_REQ-1:0]     w_onehot;
  logic                   w_launch;
  logic                   w_arm_to;
  logic                   w_active;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_sel (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_launch = (r_state == IDLE) & w_valid & ~tx_busy;
  assign w_arm_to = (r_state == ARMED) & ~tx_busy
                  & (r_cnt == ARM_LAST);
  assign w_next_ptr = (w_idx == IW'(NUM_REQ - 1))
                    ? '0 : w_idx + IW'(1);

  always_comb begin
    w_onehot = '0;
    w_onehot[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_launch) w_next = LAUNCH;
      LAUNCH:  w_next = ARMED;
      ARMED: begin
        if (tx_busy)       w_next = DRAIN;
        else if (w_arm_to) w_next = IDLE;
      end
      DRAIN: begin
        if (!tx_busy)
          w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP:     if (r_cnt == GAP_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_active = (r_state != IDLE);
  end

  // Strobes default low so they last exactly the LAUNCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      r_tx_data  <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_tx_err   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      if (w_launch) begin
        r_tx_start <= 1'b1;
        r_ack      <= w_onehot;
        r_tx_data  <= req_data[w_idx*UART_DATA_W +: UART_DATA_W];
        r_owner    <= w_idx;
        r_ptr      <= w_next_ptr;
      end
      if (w_arm_to) r_tx_err <= 1'b1;
      unique case (r_state)
        ARMED, GAP: r_cnt <= r_cnt + 8'd1;
        default:    r_cnt <= '0;
      endcase
    end
  end

  assign ack      = r_ack;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign owner    = r_owner;
  assign active   = w_active;
  assign tx_err   = r_tx_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (gap 0 and gap 5) each driving a
// behavioural transmitter that stays busy 12 clocks per frame.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tie_low = 1'b0;

  logic [3:0] ack0, ack1;
  logic       txs0, txs1;
  logic [7:0] txd0, txd1;
  logic [1:0] own0, own1;
  logic       act0, act1, err0, err1;
  logic       busy0, busy1;

  logic [1:0] mbusy;
  logic [3:0] mcnt [2];
  logic [7:0] msh [2];
  logic [1:0] mgo;
  logic       line0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .NUM_REQ(4), .GAP_CYCLES(0), .ARM_TIMEOUT(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack0), .tx_start(txs0), .tx_data(txd0),
    .tx_busy(busy0), .owner(own0), .active(act0), .tx_err(err0)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .GAP_CYCLES(5), .ARM_TIMEOUT(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack1), .tx_start(txs1), .tx_data(txd1),
    .tx_busy(busy1), .owner(own1), .active(act1), .tx_err(err1)
  );

  assign mgo   = {txs1, txs0 & ~tie_low};
  assign busy0 = mbusy[0] & ~tie_low;
  assign busy1 = mbusy[1];

  // Transmitter: cnt 0 load, 1 start, 2..9 data LSB first, 10..11 stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= '0;
      for (int k = 0; k < 2; k++) begin
        mcnt[k] <= '0;
        msh[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!mbusy[k] && mgo[k]) begin
          mbusy[k] <= 1'b1;
          mcnt[k]  <= '0;
          msh[k]   <= (k == 0) ? txd0 : txd1;
        end else if (mbusy[k]) begin
          if (mcnt[k] == 4'd11) mbusy[k] <= 1'b0;
          else mcnt[k] <= mcnt[k] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    line0 = 1'b1;
    if (mbusy[0]) begin
      if (mcnt[0] == 4'd1) line0 = 1'b0;
      else if (mcnt[0] >= 4'd2 && mcnt[0] <= 4'd9)
        line0 = msh[0][3'(mcnt[0] - 4'd2)];
    end
  end

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v == (4'b1 << i)) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    tie_low = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start0(output int s, output bit ok);
    ok = 1'b0;
    s = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (txs0) begin
        ok = 1'b1;
        s = cyc;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({txs0, txd0, ack0, own0, act0, err0} !== 17'd0) begin
      errors++;
      $display("FAIL reset_u0: got %b want 0",
               {txs0, txd0, ack0, own0, act0, err0});
    end
    checks++;
    if ({txs1, txd1, ack1, own1, act1, err1} !== 17'd0) begin
      errors++;
      $display("FAIL reset_u1: got %b want 0",
               {txs1, txd1, ack1, own1, act1, err1});
    end
  endtask

  task automatic test_single();
    logic [10:0] fr;
    do_reset();
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({txs0, ack0, txd0, own0, act0} !==
        {1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_launch: start=%b ack=%b data=%h own=%0d act=%b want 1 0100 a5 2 1",
               txs0, ack0, txd0, own0, act0);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({txs0, ack0, txd0} !== {1'b0, 4'b0000, 8'hA5}) begin
      errors++;
      $display("FAIL single_pulse_end: start=%b ack=%b data=%h want 0 0000 a5",
               txs0, ack0, txd0);
    end
    fr = 'x;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mbusy[0] && mcnt[0] >= 4'd1)
        fr[4'(mcnt[0] - 4'd1)] = line0;
    end
    checks++;
    if (fr !== {2'b11, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL single_frame: got %b want %b",
               fr, {2'b11, 8'hA5, 1'b0});
    end
    checks++;
    if ({act0, err0, txd0} !== {1'b0, 1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL single_done: act=%b err=%b data=%h want 0 0 a5",
               act0, err0, txd0);
    end
  endtask

  task automatic test_round_robin();
    int st[5];
    int who[5];
    int n = 0;
    int multi = 0;
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      st[i] = -1;
      who[i] = -1;
    end
    do_reset();
    req_data = 32'h1312_1110;
    req = 4'b1111;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge clk);
      if ($countones(ack0) > 1) multi++;
      if (txs0) begin
        st[n] = cyc;
        who[n] = oh2i(ack0);
        if (txd0 !== 8'(8'h10 + who[n])) bad++;
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d launches want 5", n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (who[i] != i % 4) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, who[i], i % 4);
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (st[i] - st[i-1] != 15) begin
        errors++;
        $display("FAIL rr_spacing[%0d]: got %0d want 15",
                 i, st[i] - st[i-1]);
      end
    end
    checks++;
    if (multi != 0 || bad != 0) begin
      errors++;
      $display("FAIL rr_ack_data: multi_ack=%0d bad_data=%0d want 0 0",
               multi, bad);
    end
  endtask

  task automatic test_gap();
    int st[3];
    int who[3];
    int n = 0;
    int hi = 0;
    logic pa = 1'b0;
    logic lowbefore = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = -1;
      who[i] = -1;
    end
    do_reset();
    req_data = 32'h0000_BBAA;
    req = 4'b0011;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (txs1) begin
        if (n == 1) lowbefore = pa;
        st[n] = cyc;
        who[n] = oh2i(ack1);
        n++;
      end
      if (n == 1 && act1) hi++;
      pa = act1;
    end
    req = '0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL gap_count: got %0d launches want 3", n);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (st[i] - st[i-1] != 20) begin
        errors++;
        $display("FAIL gap_spacing[%0d]: got %0d want 20",
                 i, st[i] - st[i-1]);
      end
    end
    checks++;
    if (who[0] != 0 || who[1] != 1 || who[2] != 0) begin
      errors++;
      $display("FAIL gap_order: got %0d %0d %0d want 0 1 0",
               who[0], who[1], who[2]);
    end
    checks++;
    if (hi != 19 || lowbefore !== 1'b0) begin
      errors++;
      $display("FAIL gap_active: high=%0d idle_act=%b want 19 0",
               hi, lowbefore);
    end
  endtask

  task automatic test_timeout();
    int s, e;
    bit ok;
    do_reset();
    tie_low = 1'b1;
    req_data = 32'h0000_005A;
    req = 4'b0001;
    wait_start0(s, ok);
    req = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_launch: got no tx_start want one");
    end
    e = -1;
    for (int i = 0; i < 20 && e < 0; i++) begin
      @(negedge clk);
      if (err0) e = cyc;
    end
    checks++;
    if (e - s != 5 || act0 !== 1'b0) begin
      errors++;
      $display("FAIL to_err: got err at +%0d act=%b want +5 0",
               e - s, act0);
    end
    tie_low = 1'b0;
    req_data = 32'h0000_7700;
    req = 4'b0010;
    wait_start0(s, ok);
    req = '0;
    checks++;
    if (!ok || ack0 !== 4'b0010 || txd0 !== 8'h77) begin
      errors++;
      $display("FAIL to_recover: ok=%0d ack=%b data=%h want 1 0010 77",
               ok, ack0, txd0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (err0 !== 1'b1 || act0 !== 1'b0) begin
      errors++;
      $display("FAIL to_sticky: err=%b act=%b want 1 0", err0, act0);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    do_reset();
    req_data = 32'h00C3_0000;
    req = 4'b0100;
    wait_start0(s, ok);
    req = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || act0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain: ok=%0d act=%b busy=%b want 1 1 1",
               ok, act0, busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({txs0, txd0, ack0, own0, act0, err0, busy0} !== 18'd0) begin
      errors++;
      $display("FAIL mid_async: got %b want 0",
               {txs0, txd0, ack0, own0, act0, err0, busy0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_data = 32'h4433_2211;
    req = 4'b1111;
    wait_start0(s, ok);
    req = '0;
    checks++;
    if (!ok || ack0 !== 4'b0001 || own0 !== 2'd0 || txd0 !== 8'h11) begin
      errors++;
      $display("FAIL mid_regrant: ok=%0d ack=%b own=%0d data=%h want 1 0001 0 11",
               ok, ack0, own0, txd0);
    end
  endtask

  task automatic test_drop();
    int s;
    int t = -1;
    int bad = 0;
    bit ok;
    bit got = 1'b0;
    do_reset();
    req_data = 32'h0400_0201;
    req = 4'b0001;
    wait_start0(s, ok);
    req = 4'b1010;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cyc == s + 13) req = 4'b1000;
      if (ack0[1]) bad++;
      if (txs0) begin
        got = 1'b1;
        t = cyc;
      end
    end
    checks++;
    if (!ok || !got || ack0 !== 4'b1000 || own0 !== 2'd3
        || txd0 !== 8'h04) begin
      errors++;
      $display("FAIL drop_grant: got=%0d ack=%b own=%0d data=%h want 1 1000 3 04",
               got, ack0, own0, txd0);
    end
    checks++;
    if (t - s != 15 || bad != 0) begin
      errors++;
      $display("FAIL drop_timing: spacing=%0d ack1=%0d want 15 0",
               t - s, bad);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_timeout();
    test_reset_mid();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one asynchronous UART transmitter between `NUM_REQ` byte requesters. It selects one pending requester and issues a one-cycle `tx_start` with the registered byte. It then tracks `tx_busy` through the whole frame and enforces an optional idle gap before the next grant. It sits between the client blocks (command echo, status reporter, debug tap) and the transmitter's `TxD_start`, `TxD_data` and `TxD_busy` pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYCLES`, default 0: idle clocks forced after `tx_busy` falls and before the next launch, 0..255.
- `ARM_TIMEOUT`, default 4: clocks allowed for `tx_busy` to rise after a launch.
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester request. Held high with data stable until acked.
- `req_data` in 8*NUM_REQ: byte for requester i is at bits [8i+7:8i].
- `ack` out NUM_REQ: one-hot, one-cycle pulse. The byte has been taken.
- `tx_start` out 1: to `TxD_start`.
- `tx_data` out 8: to `TxD_data`.
- `tx_busy` in 1: from `TxD_busy`.
- `owner` out clog2(NUM_REQ): index of the last or current granted requester.
- `active` out 1: high from launch until the gap ends.
- `tx_err` out 1: sticky. Set when `tx_busy` fails to rise within `ARM_TIMEOUT`.

## Operation
- States: IDLE, LAUNCH, ARMED, DRAIN, GAP.
- IDLE:
  - Launch condition: `|req` and `!tx_busy`.
  - Winner: the first set bit scanning upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Registers on launch: `tx_data <= req_data[winner]`, `tx_start <= 1`, `ack[winner] <= 1`, `owner <= winner`, `rr_ptr <= (winner+1) mod NUM_REQ`. Next state LAUNCH.
- LAUNCH (1 cycle): `tx_start` and `ack` are high for exactly this cycle and drop on exit. Next state ARMED with the timeout counter cleared.
- ARMED:
  - `tx_busy=1` → DRAIN.
  - Otherwise the counter increments. When it reaches `ARM_TIMEOUT`, set `tx_err` and go to IDLE. The ack is not retracted and the byte counts as lost.
- DRAIN: when `tx_busy=0`, go to GAP if `GAP_CYCLES>0`, else IDLE.
- GAP: count `GAP_CYCLES` clocks, then IDLE.
- `tx_err` clears only on reset.
- `tx_data` holds its value outside LAUNCH.
- A requester dropping `req` before ack is legal. That requester is simply not selected.
- `req` changing during ARMED, DRAIN or GAP has no effect until IDLE.
- `tx_busy` already high in IDLE (transmitter driven externally): no launch until it falls.

## Timing
- Reset values: state IDLE, `tx_start=0`, `tx_data=0`, `ack=0`, `owner=0`, `rr_ptr=0`, `active=0`, `tx_err=0`.
- Request to `tx_start` latency: `req` high in cycle N (in IDLE) gives `tx_start`/`ack` high in cycle N+1.
- The transmitter raises `tx_busy` in N+2, so ARMED normally lasts 1 cycle.
- `active` is combinational: high when state is not IDLE.
- Back-to-back throughput (GAP_CYCLES=0, frame busy B cycles): successive `tx_start` pulses are B+3 cycles apart.
- Reset asserted mid-frame: the arbiter returns to IDLE immediately. Because the transmitter shares `rst_n`, no frame survives.
- Simultaneous requests: exactly one ack per launch, never two in one cycle.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t` (IDLE=0, LAUNCH, ARMED, DRAIN, GAP);
  - constant `UART_DATA_W=8`;
  - helper function `rr_pick(req, ptr)` returning the index.
- One natural sub-module, `rr_select`: combinational round-robin priority encoder (req, ptr → valid, idx). Everything else is in the top FSM.
- Bench pairs the arbiter with the transmitter in its one-tick-per-clock simulation mode, where `TxD_busy` stays high 12 cycles per frame.

## Test plan
- Single request: req[2]=1, data 0xA5 → `ack[2]` and `tx_start` pulse together at 1 cycle latency with `tx_data=0xA5` and `owner=2`; TxD shows a start bit, then 1,0,1,0,0,1,0,1 (LSB first), then two stop bits.
- All four requesting continuously with data 0x10..0x13 → acks in order 0,1,2,3,0; `tx_start` spacing 15 cycles (B=12, GAP=0).
- GAP_CYCLES=5, two requesters → spacing 20 cycles; `active` stays high through the gap.
- `tx_busy` tied low → `tx_err` rises 4 cycles after ARMED is entered, FSM returns to IDLE, next request is still served.
- `rst_n` pulsed low during DRAIN → all outputs return to reset values asynchronously; a request after release is granted to index 0 first.
- req[1] dropped one cycle before it would win, req[3] pending → `ack[3]` issued, `ack[1]` never pulses.
